// File: rtl/hpc3_pkg.sv
// -----------------------------------------------------------------------------
// hpc3_pkg
// Shared definitions for the HPC3 fresh-randomness source:
//   - LFSR geometry (128-bit state, feedback taps 127/125/100/98)
//   - seed word geometry (32-bit words, four per full state)
//   - FSM state encoding
//   - half_rnd(d): number of fresh-bit pairs an order-d HPC3 gadget consumes
//   - lfsr_step(s): one shift of the Fibonacci LFSR
// -----------------------------------------------------------------------------
package hpc3_pkg;

  localparam int LFSR_W     = 128;
  localparam int SEED_W     = 32;
  localparam int SEED_WORDS = LFSR_W / SEED_W;

  localparam int TAP_0 = 127;
  localparam int TAP_1 = 125;
  localparam int TAP_2 = 100;
  localparam int TAP_3 = 98;

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    WARMUP,
    RUN
  } state_e;

  function automatic int half_rnd(input int d);
    return d * (d + 1) / 2;
  endfunction

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_0] ^ s[TAP_1] ^ s[TAP_2] ^ s[TAP_3]};
  endfunction

endpackage

// File: rtl/hpc3_lfsr_unroll.sv
// -----------------------------------------------------------------------------
// hpc3_lfsr_unroll
// Purely combinational: advances the 128-bit LFSR state by N steps in one
// cycle, so a single register update delivers N fresh output bits.
// Ports:
//   i_s  in  [127:0]  current LFSR state
//   o_s  out [127:0]  state after N consecutive steps
// -----------------------------------------------------------------------------
module hpc3_lfsr_unroll
  import hpc3_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [LFSR_W-1:0] i_s,
  output logic [LFSR_W-1:0] o_s
);

  logic [LFSR_W-1:0] w_s;

  always_comb begin
    w_s = i_s;
    // NOTE: blocking assignments chain each step onto the previous one within
    // a single evaluation; this is what makes the loop a combinational unroll.
    for (int i = 0; i < N; i++) begin
      w_s = lfsr_step(w_s);
    end
  end

  assign o_s = w_s;

endmodule

// File: rtl/hpc3_rnd_source.sv
// -----------------------------------------------------------------------------
// hpc3_rnd_source
// Fresh-randomness producer for one masked HPC3 gadget. A 128-bit LFSR is
// loaded with four 32-bit seed words, free-runs for warmup_cycles advances
// with its output hidden, then offers RND_W bits per valid/ready transfer.
// Each advance moves the LFSR RND_W steps, so no output bit is reused.
//
// Parameters:
//   security_order  masking order d; RND_W = 2*d*(d+1)/2
//   warmup_cycles   advances between seeding and first valid output (1..255)
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   seed_data   in   [31:0] seed word
//   seed_valid  in   seed word present
//   seed_ready  out  seed word accepted (IDLE/SEED)
//   reseed      in   one-cycle pulse: abandon stream, wait for new seed
//   rnd_out     out  [RND_W-1:0] randomness for the gadget r port
//   rnd_valid   out  rnd_out fresh and unused (RUN)
//   rnd_ready   in   consumer takes rnd_out this cycle
//   busy        out  seeding or warming up
// -----------------------------------------------------------------------------
module hpc3_rnd_source
  import hpc3_pkg::*;
#(
  parameter  int security_order = 1,
  parameter  int warmup_cycles  = 16,
  localparam int RND_W          = 2 * half_rnd(security_order)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEED_W-1:0] seed_data,
  input  logic              seed_valid,
  output logic              seed_ready,
  input  logic              reseed,
  output logic [RND_W-1:0]  rnd_out,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              busy
);

  if (RND_W < 1 || RND_W > LFSR_W) begin : g_bad_rnd_w
    $error("hpc3_rnd_source: RND_W=%0d must be in 1..%0d", RND_W, LFSR_W);
  end
  if (warmup_cycles < 1 || warmup_cycles > 255) begin : g_bad_warmup
    $error("hpc3_rnd_source: warmup_cycles=%0d must be in 1..255", warmup_cycles);
  end

  localparam logic [7:0] WARM_LAST = 8'(warmup_cycles - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_k;
  logic [1:0]        w_k_nxt;
  logic [7:0]        r_cnt;
  logic [7:0]        w_cnt_nxt;
  logic [LFSR_W-1:0] r_s;
  logic [LFSR_W-1:0] w_s_nxt;
  logic [LFSR_W-1:0] w_s_adv;
  logic              w_zero_seed;

  hpc3_lfsr_unroll #(
    .N (RND_W)
  ) u_unroll (
    .i_s (r_s),
    .o_s (w_s_adv)
  );

  // Words 0..2 of the current seeding already sit in the low 96 bits when the
  // final word arrives, so the all-zero test needs no extra storage.
  assign w_zero_seed = (r_s[3*SEED_W-1:0] == '0) && (seed_data == '0);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case below can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_cnt_nxt   = r_cnt;
    w_s_nxt     = r_s;

    if (reseed) begin
      // Reseed wins over any seed word or handshake in the same cycle; the
      // LFSR contents are kept but never shown again before a full reload.
      w_state_nxt = IDLE;
      w_k_nxt     = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE, SEED: begin
          if (seed_valid) begin
            w_s_nxt[{r_k, 5'd0} +: SEED_W] = seed_data;
            if (r_k == 2'(SEED_WORDS - 1)) begin
              // An all-zero state is the LFSR's fixed point; escape it.
              if (w_zero_seed) w_s_nxt[0] = 1'b1;
              w_k_nxt     = '0;
              w_state_nxt = WARMUP;
            end else begin
              w_k_nxt     = r_k + 2'd1;
              w_state_nxt = SEED;
            end
          end
        end
        WARMUP: begin
          w_s_nxt = w_s_adv;
          if (r_cnt == WARM_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = RUN;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        RUN: begin
          if (rnd_ready) w_s_nxt = w_s_adv;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_cnt   <= w_cnt_nxt;
      r_s     <= w_s_nxt;
    end
  end

  assign seed_ready = (r_state == IDLE) || (r_state == SEED);
  assign busy       = (r_state == SEED) || (r_state == WARMUP);
  assign rnd_valid  = (r_state == RUN);
  assign rnd_out    = r_s[RND_W-1:0];

endmodule

// File: tb/tb_hpc3_rnd_source.sv
// -----------------------------------------------------------------------------
// tb_hpc3_rnd_source
// Two instances share clock and reset: d=1 (2-bit output) and d=2 (6-bit
// output), both with 16 warm-up cycles. A select bit routes stimulus to one
// instance at a time. Expected words come from an independent LFSR model and
// are queued; every observed handshake pops and compares one entry.
// -----------------------------------------------------------------------------
module tb_hpc3_rnd_source;

  localparam int WARM = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] seed_data = '0;
  logic        seed_valid = 1'b0;
  logic        reseed = 1'b0;
  logic        rnd_ready = 1'b0;
  bit          sel = 1'b0;

  logic       sready1, valid1, busy1;
  logic [1:0] out1;
  logic       sready2, valid2, busy2;
  logic [5:0] out2;

  logic       act_sready, act_valid, act_busy;
  logic [5:0] act_out;

  always #5 clk = ~clk;

  hpc3_rnd_source #(.security_order(1), .warmup_cycles(WARM)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_data  (seed_data),
    .seed_valid (seed_valid & ~sel),
    .seed_ready (sready1),
    .reseed     (reseed & ~sel),
    .rnd_out    (out1),
    .rnd_valid  (valid1),
    .rnd_ready  (rnd_ready & ~sel),
    .busy       (busy1)
  );

  hpc3_rnd_source #(.security_order(2), .warmup_cycles(WARM)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_data  (seed_data),
    .seed_valid (seed_valid & sel),
    .seed_ready (sready2),
    .reseed     (reseed & sel),
    .rnd_out    (out2),
    .rnd_valid  (valid2),
    .rnd_ready  (rnd_ready & sel),
    .busy       (busy2)
  );

  assign act_sready = sel ? sready2 : sready1;
  assign act_valid  = sel ? valid2  : valid1;
  assign act_busy   = sel ? busy2   : busy1;
  assign act_out    = sel ? out2    : {4'b0, out1};

  typedef struct {
    logic [127:0] seed;
    bit           sel;
    logic [127:0] start;  // LFSR state expected on entry to warm-up
  } vec_t;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [127:0] m_s;
  logic [5:0]   exp_q[$];
  logic         prev_valid  = 1'b0;
  logic         prev_ready  = 1'b0;
  logic         prev_reseed = 1'b0;
  logic [5:0]   prev_out    = '0;
  bit           chk_drop    = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] model_adv(input logic [127:0] s, input int steps);
    logic [127:0] v = s;
    for (int i = 0; i < steps; i++) begin
      v = {v[126:0], v[127] ^ v[125] ^ v[100] ^ v[98]};
    end
    return v;
  endfunction

  function automatic int cur_w();
    return sel ? 6 : 2;
  endfunction

  function automatic logic [5:0] exp_word(input logic [127:0] s);
    return sel ? s[5:0] : {4'b0, s[1:0]};
  endfunction

  // One clock cycle: observe at the falling edge, then return just after the
  // next rising edge so callers can change inputs safely.
  task automatic step();
    @(negedge clk);
    if (rst_n && prev_valid && !prev_reseed) begin
      if (chk_drop) check("valid_hold", act_valid, 1'b1);
      if (!prev_ready && act_valid) check("stall_stable", act_out, prev_out);
    end
    if (rst_n && act_valid && rnd_ready && !reseed) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty: got %0h, expected no handshake", act_out);
      end else begin
        check("rnd_word", act_out, exp_q.pop_front());
      end
      m_s = model_adv(m_s, cur_w());
      exp_q.push_back(exp_word(m_s));
    end
    prev_valid  = rst_n & act_valid;
    prev_ready  = rnd_ready;
    prev_reseed = reseed;
    prev_out    = act_out;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_seed(input vec_t v);
    int lat;
    sel = v.sel;
    for (int k = 0; k < 4; k++) begin
      seed_data  = v.seed[32*k +: 32];
      seed_valid = 1'b1;
      check("seed_ready", act_sready, 1'b1);
      step();
    end
    seed_valid = 1'b0;
    seed_data  = '0;
    check("busy_warm", act_busy, 1'b1);
    check("valid_warm", act_valid, 1'b0);
    lat = 1;
    while (!act_valid && lat < 300) begin
      step();
      lat++;
    end
    check("latency", lat, 1 + WARM);
    check("busy_run", act_busy, 1'b0);
    m_s = model_adv(v.start, WARM * cur_w());
    exp_q.delete();
    exp_q.push_back(exp_word(m_s));
  endtask

  task automatic run_ready(input int n);
    rnd_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    rnd_ready = 1'b0;
  endtask

  task automatic reseed_pulse(input logic rdy);
    rnd_ready = rdy;
    reseed    = 1'b1;
    step();
    reseed    = 1'b0;
    rnd_ready = 1'b0;
    exp_q.delete();
  endtask

  vec_t       vecs[3];
  vec_t       v;
  logic [5:0] held;

  initial begin
    vecs[0] = '{seed: 128'h1, sel: 1'b0, start: 128'h1};
    vecs[1] = '{seed: 128'h0, sel: 1'b0, start: 128'h1};
    vecs[2] = '{seed: 128'h0123456789abcdef_fedcba9876543210, sel: 1'b1,
                start: 128'h0123456789abcdef_fedcba9876543210};

    // Reset values on both instances.
    #2;
    check("rst_sready1", sready1, 1'b1);
    check("rst_valid1", valid1, 1'b0);
    check("rst_busy1", busy1, 1'b0);
    check("rst_out1", out1, 2'b0);
    check("rst_sready2", sready2, 1'b1);
    check("rst_valid2", valid2, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_out2", out2, 6'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    // Table-driven seeding: latency and the first stream words.
    for (int i = 0; i < 3; i++) begin
      apply_seed(vecs[i]);
      run_ready(8);
      reseed_pulse(1'b0);
      check("idle_after_reseed", act_sready, 1'b1);
    end

    // d=2: five stalled cycles keep the word, then the stream resumes.
    v = '{seed: 128'hcafef00d_12345678_9abcdef0_0badc0de, sel: 1'b1,
          start: 128'hcafef00d_12345678_9abcdef0_0badc0de};
    apply_seed(v);
    run_ready(3);
    held = act_out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_word", act_out, held);
      check("stall_valid", act_valid, 1'b1);
    end
    run_ready(10);

    // Reseed concurrent with a handshake: no advance, valid drops.
    held = act_out;
    reseed_pulse(1'b1);
    check("rs_valid", act_valid, 1'b0);
    check("rs_sready", act_sready, 1'b1);
    check("rs_no_adv", act_out, held);
    v = '{seed: {4{32'hdeadbeef}}, sel: 1'b1, start: {4{32'hdeadbeef}}};
    apply_seed(v);
    run_ready(8);
    reseed_pulse(1'b0);

    // Asynchronous reset after two of four seed words.
    sel = 1'b1;
    for (int k = 0; k < 2; k++) begin
      seed_data  = 32'h5a5a_0000 + 32'(k);
      seed_valid = 1'b1;
      step();
    end
    seed_valid = 1'b0;
    check("mid_busy_before", act_busy, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sready", act_sready, 1'b1);
    check("mid_rst_busy", act_busy, 1'b0);
    check("mid_rst_valid", act_valid, 1'b0);
    check("mid_rst_out", act_out, 6'b0);
    step();
    rst_n = 1'b1;
    step();
    v = '{seed: 128'h1, sel: 1'b1, start: 128'h1};
    apply_seed(v);
    run_ready(8);

    // Long run with random consumer back-pressure.
    chk_drop = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      rnd_ready = 1'($urandom_range(0, 1));
      step();
    end
    rnd_ready = 1'b0;
    chk_drop  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
